wbuf_pingpong: RTL and testbench

WBUF_PINGPONG -- requirements
Module: wbuf_pingpong

---
 rtl/wbuf_pingpong.sv | 122 ++++++++++++
 tb/tb_wbuf_pingpong.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_pingpong.sv
// Ping-pong weight buffer: serial elements pack into LANES-wide rows in the write bank
// while the read bank streams rows out. Optional block replay via `WBUF_REPLAY_EN.
module wbuf_pingpong #(
   parameter int DW    = 8,
   parameter int LANES = 4,
   parameter int DEPTH = 16,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DW-1:0]       in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                swap_req,
   output logic                swap_ack,
   output logic [LANES*DW-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CW-1:0]       wr_rows,
   output logic [CW-1:0]       rd_rows
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef logic [LANES-1:0][DW-1:0] row_t;

   logic          sel;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] lane_cnt;
   row_t          row_buf;
   row_t          commit_row;
   row_t          mem [0:2*DEPTH-1];

   logic wr_fire;
   logic last_lane;
   logic commit;
   logic rd_fire;
   logic swap_ok;
   logic swap_fire;

`ifdef WBUF_REPLAY_EN
   logic [CW-1:0] rd_len;
`endif

   // NOTE: every signal assigned in always_comb gets a value before any condition, so no latch is inferred.
   always_comb begin
      in_ready   = wr_rows < CW'(DEPTH);
      wr_fire    = in_valid & in_ready;
      last_lane  = lane_cnt == LW'(LANES - 1);
      commit     = wr_fire & last_lane;
      out_valid  = rd_rows != '0;
      rd_fire    = out_valid & out_ready;
      commit_row = row_buf;
      commit_row[LANES-1] = in_data;
`ifdef WBUF_REPLAY_EN
      swap_ok    = (wr_rows != '0) && (lane_cnt == '0);
`else
      swap_ok    = (wr_rows != '0) && (lane_cnt == '0) && (rd_rows == '0);
`endif
      swap_fire  = swap_req & swap_ok;
      out_data   = mem[{~sel, rd_ptr}];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel      <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         wr_rows  <= '0;
         rd_rows  <= '0;
         lane_cnt <= '0;
         swap_ack <= 1'b0;
`ifdef WBUF_REPLAY_EN
         rd_len   <= '0;
`endif
      end else begin
         swap_ack <= swap_fire;
         if (wr_fire) lane_cnt <= last_lane ? '0 : lane_cnt + LW'(1);

         if (swap_fire) begin
            // A row completing on this edge lands in the old bank and travels with the count.
            sel     <= ~sel;
            rd_rows <= wr_rows + CW'(commit);
            wr_rows <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
`ifdef WBUF_REPLAY_EN
            rd_len  <= wr_rows + CW'(commit);
`endif
         end else begin
            if (commit) begin
               wr_ptr  <= wr_ptr + PW'(1);
               wr_rows <= wr_rows + CW'(1);
            end
            if (rd_fire) begin
`ifdef WBUF_REPLAY_EN
               if (CW'(rd_ptr) + CW'(1) == rd_len) begin
                  rd_ptr  <= '0;
                  rd_rows <= rd_len;
               end else begin
                  rd_ptr  <= rd_ptr + PW'(1);
                  rd_rows <= rd_rows - CW'(1);
               end
`else
               rd_ptr  <= rd_ptr + PW'(1);
               rd_rows <= rd_rows - CW'(1);
`endif
            end
         end
      end
   end

   // NOTE: storage is deliberately not reset; only control state clears, keeping the array a plain RAM.
   always_ff @(posedge clk) begin
      if (wr_fire && !last_lane) row_buf[lane_cnt] <= in_data;
      if (commit) mem[{sel, wr_ptr}] <= commit_row;
   end

endmodule

// File: tb/tb_wbuf_pingpong.sv
// Directed self-checking bench for wbuf_pingpong (DW=8, LANES=4, DEPTH=16);
// the replay expectations apply when WBUF_REPLAY_EN is defined.
module tb_wbuf_pingpong;

   localparam int DW    = 8;
   localparam int LANES = 4;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic                clk;
   logic                rst_n;
   logic [DW-1:0]       in_data;
   logic                in_valid;
   logic                in_ready;
   logic                swap_req;
   logic                swap_ack;
   logic [LANES*DW-1:0] out_data;
   logic                out_valid;
   logic                out_ready;
   logic [CW-1:0]       wr_rows;
   logic [CW-1:0]       rd_rows;

   int tests = 0;
   int fails = 0;

   wbuf_pingpong #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .swap_req  (swap_req),
      .swap_ack  (swap_ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wr_rows   (wr_rows),
      .rd_rows   (rd_rows)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after a rising edge; outputs are checked at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic push_row(input logic [DW-1:0] base);
      for (int l = 1; l <= LANES; l++) push(base + DW'(l));
   endtask

   initial begin
      logic [LANES*DW-1:0] exp_row;

      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      swap_req  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("reset_in_ready",  in_ready,  1);
      check("reset_out_valid", out_valid, 0);
      check("reset_wr_rows",   wr_rows,   0);
      check("reset_rd_rows",   rd_rows,   0);
      check("reset_swap_ack",  swap_ack,  0);
      #11 rst_n = 1'b1;
      step();

      // Basic packing and swap
      for (int i = 1; i <= 8; i++) push(DW'(i));
      check("t1_wr_rows",   wr_rows,   2);
      check("t1_out_valid", out_valid, 0);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      check("t1_swap_ack",  swap_ack, 1);
      check("t1_rd_rows",   rd_rows,  2);
      check("t1_wr_rows0",  wr_rows,  0);
      check("t1_row0",      out_data, 32'h04030201);
      out_ready = 1'b1;
      step();
      check("t1_ack_pulse", swap_ack, 0);
      check("t1_row1",      out_data, 32'h08070605);
      check("t1_rd_rows1",  rd_rows,  1);
      step();
      out_ready = 1'b0;
      check("t1_drained",   out_valid, 0);

      // Swap held off by a partial row
      for (int i = 1; i <= 6; i++) push(8'h10 + DW'(i));
      check("t2_wr_rows", wr_rows, 1);
      swap_req = 1'b1;
      step();
      check("t2_no_ack_a", swap_ack, 0);
      step();
      check("t2_no_ack_b", swap_ack, 0);
      push(8'h17);
      check("t2_no_ack_c", swap_ack, 0);
      push(8'h18);
      check("t2_no_ack_d", swap_ack, 0);
      check("t2_wr_rows2", wr_rows,  2);
      step();
      swap_req = 1'b0;
      check("t2_ack",     swap_ack, 1);
      check("t2_rd_rows", rd_rows,  2);
      check("t2_row0",    out_data, 32'h14131211);
      out_ready = 1'b1;
      step();
      check("t2_row1",    out_data, 32'h18171615);
      step();
      out_ready = 1'b0;
      check("t2_drained", rd_rows, 0);

      // Full bank, dropped extras, exact read-back
      for (int i = 0; i < DEPTH * LANES; i++) push(8'h40 + DW'(i));
      check("t3_in_ready", in_ready, 0);
      check("t3_wr_rows",  wr_rows,  DEPTH);
      for (int i = 0; i < 3; i++) push(8'hEE);
      check("t3_wr_rows_hold", wr_rows, DEPTH);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      check("t3_ack",       swap_ack, 1);
      check("t3_rd_rows",   rd_rows,  DEPTH);
      check("t3_in_ready1", in_ready, 1);
      out_ready = 1'b1;
      for (int r = 0; r < DEPTH; r++) begin
         for (int l = 0; l < LANES; l++) exp_row[l*DW +: DW] = 8'h40 + DW'(r * LANES + l);
         check($sformatf("t3_row%0d", r), out_data, exp_row);
         step();
      end
      out_ready = 1'b0;
      check("t3_drained", rd_rows, 0);

      // Swap waits for the read bank to drain (or replays)
      push_row(8'hA0);
      check("t4_lane_clean", wr_rows, 1);
      push_row(8'hB0);
      push_row(8'hC0);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      check("t4_ack0",    swap_ack, 1);
      check("t4_rd_rows", rd_rows,  3);
      push_row(8'hD0);
      check("t4_wr_rows", wr_rows,  1);
      check("t4_rowA",    out_data, 32'hA4A3A2A1);
`ifdef WBUF_REPLAY_EN
      out_ready = 1'b1;
      step();
      check("t4_rowB",   out_data, 32'hB4B3B2B1);
      check("t4_rd2",    rd_rows,  2);
      step();
      check("t4_rowC",   out_data, 32'hC4C3C2C1);
      check("t4_rd1",    rd_rows,  1);
      step();
      out_ready = 1'b0;
      check("t4_replay", out_data, 32'hA4A3A2A1);
      check("t4_reload", rd_rows,  3);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      check("t4_ack",    swap_ack, 1);
`else
      swap_req  = 1'b1;
      out_ready = 1'b1;
      step();
      check("t4_no_ack1", swap_ack, 0);
      check("t4_rd2",     rd_rows,  2);
      check("t4_rowB",    out_data, 32'hB4B3B2B1);
      step();
      check("t4_no_ack2", swap_ack, 0);
      check("t4_rd1",     rd_rows,  1);
      check("t4_rowC",    out_data, 32'hC4C3C2C1);
      step();
      check("t4_no_ack3", swap_ack, 0);
      check("t4_empty",   out_valid, 0);
      step();
      swap_req  = 1'b0;
      out_ready = 1'b0;
      check("t4_ack",     swap_ack, 1);
`endif
      check("t4_rd_new",  rd_rows,  1);
      check("t4_rowD",    out_data, 32'hD4D3D2D1);
      check("t4_wr_zero", wr_rows,  0);

      // Asynchronous reset mid-fill
      push_row(8'hE0);
      push(8'hF1);
      push(8'hF2);
      check("t5_pre_wr", wr_rows, 1);
      check("t5_pre_rd", rd_rows, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_wr",       wr_rows,   0);
      check("t5_rst_rd",       rd_rows,   0);
      check("t5_rst_outvalid", out_valid, 0);
      check("t5_rst_inready",  in_ready,  1);
      #3 rst_n = 1'b1;
      step();
      push_row(8'h50);
      check("t5_wr_rows", wr_rows, 1);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      check("t5_ack",     swap_ack, 1);
      check("t5_rd_rows", rd_rows,  1);
      check("t5_row",     out_data, 32'h54535251);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
